// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Holds the default geometry and the architectural special register indices.
package regfile_sb_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ADDR_W   = 4;
    localparam int unsigned DEF_ZERO_IDX = 0;
    localparam int unsigned DEF_PC_IDX   = 15;
    localparam int unsigned DEF_T_IDX    = 14;
    localparam int unsigned DEF_PEEK_IDX = 3;

    // The zero register and the PC alias are hard-wired; every other index holds state.
    function automatic logic isWritable(input int unsigned idx,
                                        input int unsigned zeroIdx,
                                        input int unsigned pcIdx);
        return (idx != zeroIdx) && (idx != pcIdx);
    endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: special indices, write-through bypass and hazard stall.
module regfile_sb_rdport
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_IDX = DEF_ZERO_IDX,
    parameter int unsigned PC_IDX   = DEF_PC_IDX
) (
    input  logic [ADDR_W-1:0]    raddr_i,
    input  logic [DATA_W-1:0]    storage_i [2**ADDR_W],
    input  logic [2**ADDR_W-1:0] pend_i,
    input  logic [DATA_W-1:0]    pcAddr_i,
    input  logic                 bypVld_i,
    input  logic [ADDR_W-1:0]    bypReg_i,
    input  logic [DATA_W-1:0]    bypData_i,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 stall_o
);

    logic bypHit;

    assign bypHit = bypVld_i && (bypReg_i == raddr_i);

    // A writeback landing this cycle resolves the hazard and supplies the data early.
    always_comb begin
        rdata_o = storage_i[raddr_i];
        stall_o = pend_i[raddr_i] && !bypHit;
        if (raddr_i == ADDR_W'(ZERO_IDX)) begin
            rdata_o = '0;
            stall_o = 1'b0;
        end else if (raddr_i == ADDR_W'(PC_IDX)) begin
            rdata_o = pcAddr_i;
            stall_o = 1'b0;
        end else if (bypHit) begin
            rdata_o = bypData_i;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-through bypass and a per-register pending scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_IDX = DEF_ZERO_IDX,
    parameter int unsigned PC_IDX   = DEF_PC_IDX,
    parameter int unsigned T_IDX    = DEF_T_IDX,
    parameter int unsigned PEEK_IDX = DEF_PEEK_IDX
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] raddrA_i,
    output logic [DATA_W-1:0] rdataA_o,
    input  logic [ADDR_W-1:0] raddrB_i,
    output logic [DATA_W-1:0] rdataB_o,
    input  logic [DATA_W-1:0] pcAddr_i,
    input  logic              issueVld_i,
    input  logic [ADDR_W-1:0] issueReg_i,
    input  logic              wrVld_i,
    input  logic [ADDR_W-1:0] wrReg_i,
    input  logic [DATA_W-1:0] wrData_i,
    output logic              stallA_o,
    output logic              stallB_o,
    output logic [ADDR_W:0]   pendCnt_o,
    output logic [DATA_W-1:0] regPeek_o
);

    localparam int unsigned NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [NUM_REGS-1:0] setVec, clrVec;
    logic [ADDR_W:0]     pendCnt_q, pendCnt_d;
    logic                newSet, realClr;
    logic                bypVld;
    logic [DATA_W-1:0]   wrValue;

    // Bypass is suppressed while in reset so reads show the cleared file.
    assign bypVld  = wrVld_i && rst_ni;
    assign wrValue = (wrReg_i == ADDR_W'(T_IDX)) ?
                     {{(DATA_W-1){1'b0}}, (wrData_i == '0)} : wrData_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrVld_i && isWritable(32'(wrReg_i), ZERO_IDX, PC_IDX)) begin
            regs_q[wrReg_i] <= wrValue;
        end
    end

    // Set wins over clear on the same index: the freshly issued producer is still outstanding.
    always_comb begin
        setVec = '0;
        clrVec = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            setVec[i] = issueVld_i && (issueReg_i == ADDR_W'(i)) &&
                        isWritable(i, ZERO_IDX, PC_IDX);
            clrVec[i] = wrVld_i && (wrReg_i == ADDR_W'(i));
        end
        pend_d    = (pend_q & ~clrVec) | setVec;
        newSet    = |(setVec & ~pend_q);
        realClr   = |(clrVec & pend_q & ~setVec);
        pendCnt_d = pendCnt_q + (ADDR_W+1)'(newSet) - (ADDR_W+1)'(realClr);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q    <= '0;
            pendCnt_q <= '0;
        end else begin
            pend_q    <= pend_d;
            pendCnt_q <= pendCnt_d;
        end
    end

    assign pendCnt_o = pendCnt_q;
    assign regPeek_o = regs_q[PEEK_IDX];

    regfile_sb_rdport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_IDX(ZERO_IDX), .PC_IDX(PC_IDX)
    ) uPortA (
        .raddr_i(raddrA_i), .storage_i(regs_q), .pend_i(pend_q), .pcAddr_i(pcAddr_i),
        .bypVld_i(bypVld), .bypReg_i(wrReg_i), .bypData_i(wrValue),
        .rdata_o(rdataA_o), .stall_o(stallA_o)
    );

    regfile_sb_rdport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_IDX(ZERO_IDX), .PC_IDX(PC_IDX)
    ) uPortB (
        .raddr_i(raddrB_i), .storage_i(regs_q), .pend_i(pend_q), .pcAddr_i(pcAddr_i),
        .bypVld_i(bypVld), .bypReg_i(wrReg_i), .bypData_i(wrValue),
        .rdata_o(rdataB_o), .stall_o(stallB_o)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: array-based reference model checked every cycle,
// plus directed literal checks for the special indices, scoreboard and reset cases.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  raddrA, raddrB, issueReg, wrReg;
    logic [15:0] rdataA, rdataB, pcAddr, wrData, regPeek;
    logic        issueVld, wrVld, stallA, stallB;
    logic [4:0]  pendCnt;

    int nChecks = 0;
    int nFail   = 0;

    logic [15:0] mRegs [16];
    logic        mPend [16];

    regfile_sb dut (
        .clk_i(clk), .rst_ni(rst_n),
        .raddrA_i(raddrA), .rdataA_o(rdataA),
        .raddrB_i(raddrB), .rdataB_o(rdataB),
        .pcAddr_i(pcAddr),
        .issueVld_i(issueVld), .issueReg_i(issueReg),
        .wrVld_i(wrVld), .wrReg_i(wrReg), .wrData_i(wrData),
        .stallA_o(stallA), .stallB_o(stallB),
        .pendCnt_o(pendCnt), .regPeek_o(regPeek)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] tVal(input logic [3:0] r, input logic [15:0] d);
        if (r == 4'd14) return (d == 16'h0) ? 16'h0001 : 16'h0000;
        return d;
    endfunction

    function automatic logic [15:0] expRead(input logic [3:0] a);
        if (a == 4'd0)  return 16'h0000;
        if (a == 4'd15) return pcAddr;
        if (rst_n && wrVld && wrReg == a) return tVal(wrReg, wrData);
        return mRegs[a];
    endfunction

    function automatic logic expStall(input logic [3:0] a);
        if (a == 4'd0 || a == 4'd15) return 1'b0;
        return mPend[a] && !(rst_n && wrVld && wrReg == a);
    endfunction

    function automatic logic [15:0] expCount();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(mPend[i]);
        return 16'(n);
    endfunction

    // Reference model: architectural state as plain arrays, popcount derived on demand.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mRegs[i] <= 16'h0;
                mPend[i] <= 1'b0;
            end
        end else begin
            if (wrVld) begin
                if (wrReg != 4'd0 && wrReg != 4'd15) mRegs[wrReg] <= tVal(wrReg, wrData);
                mPend[wrReg] <= 1'b0;
            end
            if (issueVld && issueReg != 4'd0 && issueReg != 4'd15) mPend[issueReg] <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cmpRdataA",  rdataA,          expRead(raddrA));
        checkOutput("cmpRdataB",  rdataB,          expRead(raddrB));
        checkOutput("cmpStallA",  16'(stallA),     16'(expStall(raddrA)));
        checkOutput("cmpStallB",  16'(stallB),     16'(expStall(raddrB)));
        checkOutput("cmpPendCnt", 16'(pendCnt),    expCount());
        checkOutput("cmpPeek",    regPeek,         mRegs[3]);
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic iv, input logic [3:0] ir,
                                 input logic wv, input logic [3:0] wr, input logic [15:0] wd);
        issueVld = iv; issueReg = ir;
        wrVld = wv; wrReg = wr; wrData = wd;
    endtask

    initial begin
        rst_n = 1'b0; pcAddr = 16'h0042;
        raddrA = 4'd5; raddrB = 4'd15;
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
        #3;
        checkOutput("rstRdA5",   rdataA, 16'h0000);
        checkOutput("rstRdB15",  rdataB, 16'h0042);
        checkOutput("rstCnt",    16'(pendCnt), 16'h0);
        checkOutput("rstStallA", 16'(stallA), 16'h0);
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        checkOutput("postRstRdA5",  rdataA, 16'h0000);
        checkOutput("postRstRdB15", rdataB, 16'h0042);

        // Write then read, with same-cycle bypass on port B.
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd5, 16'h1234);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd6, 16'hBEEF);
        raddrA = 4'd5; raddrB = 4'd6;
        #1;
        checkOutput("rdA5",      rdataA, 16'h1234);
        checkOutput("bypassB6",  rdataB, 16'hBEEF);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
        #1;
        checkOutput("storedB6",  rdataB, 16'hBEEF);

        // Special indices.
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd0, 16'hFFFF); raddrA = 4'd0;
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
        #1 checkOutput("zeroReg", rdataA, 16'h0000);
        pcAddr = 16'h0100;
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd15, 16'h7777); raddrA = 4'd15;
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
        #1 checkOutput("pcReg", rdataA, 16'h0100);
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd14, 16'h0000); raddrA = 4'd14;
        #1 checkOutput("tBypass", rdataA, 16'h0001);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
        #1 checkOutput("tZero", rdataA, 16'h0001);
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd14, 16'h0003);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
        #1 checkOutput("tNonZero", rdataA, 16'h0000);
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd3, 16'hA5A5);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
        #1 checkOutput("peek", regPeek, 16'hA5A5);

        // Scoreboard set and resolve.
        applyStimulus(1'b1, 4'd7, 1'b0, 4'd0, 16'h0);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0); raddrA = 4'd7;
        #1;
        checkOutput("issueStall", 16'(stallA),  16'h1);
        checkOutput("issueCnt",   16'(pendCnt), 16'h1);
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd7, 16'h0009);
        #1;
        checkOutput("wbStall", 16'(stallA), 16'h0);
        checkOutput("wbData",  rdataA, 16'h0009);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
        #1 checkOutput("wbCnt", 16'(pendCnt), 16'h0);

        // Issue and write to the same pending index: set wins.
        applyStimulus(1'b1, 4'd4, 1'b0, 4'd0, 16'h0);
        cycle();
        applyStimulus(1'b1, 4'd4, 1'b1, 4'd4, 16'h0044);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0); raddrA = 4'd4;
        #1;
        checkOutput("sameStall", 16'(stallA),  16'h1);
        checkOutput("sameCnt",   16'(pendCnt), 16'h1);
        checkOutput("sameData",  rdataA, 16'h0044);
        applyStimulus(1'b1, 4'd9, 1'b1, 4'd4, 16'h0004);
        cycle();
        applyStimulus(1'b1, 4'd8, 1'b1, 4'd9, 16'h0099);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0); raddrA = 4'd8; raddrB = 4'd9;
        #1;
        checkOutput("swapCnt",    16'(pendCnt), 16'h1);
        checkOutput("swapStallA", 16'(stallA),  16'h1);
        checkOutput("swapStallB", 16'(stallB),  16'h0);
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd8, 16'h0088);
        cycle();

        // Reset in the middle of outstanding work.
        applyStimulus(1'b1, 4'd1, 1'b1, 4'd1, 16'h1111);
        cycle();
        applyStimulus(1'b1, 4'd2, 1'b0, 4'd0, 16'h0);
        cycle();
        applyStimulus(1'b1, 4'd5, 1'b0, 4'd0, 16'h0);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0); raddrA = 4'd1; raddrB = 4'd2;
        #1 checkOutput("preRstCnt", 16'(pendCnt), 16'h3);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midRstCnt",    16'(pendCnt), 16'h0);
        checkOutput("midRstStallA", 16'(stallA),  16'h0);
        checkOutput("midRstStallB", 16'(stallB),  16'h0);
        checkOutput("midRstR1",     rdataA, 16'h0000);
        applyStimulus(1'b1, 4'd6, 1'b1, 4'd6, 16'h6666); raddrB = 4'd6;
        #1 checkOutput("rstNoBypass", rdataB, 16'h0000);
        cycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
        rst_n = 1'b1;
        #1 checkOutput("rstNoWrite", rdataB, 16'h0000);

        // Mixed traffic, judged by the per-cycle model comparison.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'(i % 3 != 0), 4'((i * 5) % 16), 1'(i % 2 == 0),
                          4'((i * 7 + 3) % 16), 16'(i * 16'h0123));
            raddrA = 4'((i * 3) % 16);
            raddrB = 4'((i * 7 + 3) % 16);
            cycle();
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd0, 16'h0);
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
